// File: rtl/fan_cmd_pkg.sv
// Shared command codes and ASCII constants for the fan controller command path.
// Also used by the burst sequencer and the LED mapping.
package fan_cmd_pkg;

  localparam int unsigned CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_SPEED0 = 3'd0,
    CMD_SPEED1 = 3'd1,
    CMD_SPEED2 = 3'd2,
    CMD_SPEED3 = 3'd3,
    CMD_LIGHT  = 3'd4,
    CMD_NONE   = 3'd7
  } fan_cmd_e;

  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_1       = 8'h31;
  localparam logic [7:0] ASCII_2       = 8'h32;
  localparam logic [7:0] ASCII_3       = 8'h33;
  localparam logic [7:0] ASCII_L_LOWER = 8'h6C;
  localparam logic [7:0] ASCII_L_UPPER = 8'h4C;

  typedef struct packed {
    logic             hit;
    logic [CMD_W-1:0] code;
  } rx_decode_t;

  // Unknown bytes decode to no hit; the caller ignores them without counting a drop.
  function automatic rx_decode_t decode_rx(input logic [7:0] b);
    rx_decode_t d;
    d.hit  = 1'b1;
    d.code = CMD_NONE;
    unique case (b)
      ASCII_0:                      d.code = CMD_SPEED0;
      ASCII_1:                      d.code = CMD_SPEED1;
      ASCII_2:                      d.code = CMD_SPEED2;
      ASCII_3:                      d.code = CMD_SPEED3;
      ASCII_L_LOWER, ASCII_L_UPPER: d.code = CMD_LIGHT;
      default:                      d.hit  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, hold-time debouncer, stable level and
// a one-cycle press pulse on each stable released->pressed transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic w_level;
  logic w_differs;
  logic w_expire;

  assign w_level   = ~r_sync2;
  assign w_differs = w_level ^ r_stable;
  assign w_expire  = w_differs && (r_cnt == CntMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      // Pulse is registered alongside the flip so it lines up with the new stable level.
      r_press <= w_expire & ~r_stable;
      if (w_expire) begin
        r_stable <= ~r_stable;
      end
      if (!w_differs || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pressed = r_stable;
  assign press   = r_press;

endmodule

// File: rtl/fan_cmd_frontend.sv
// Merges UART command bytes and four debounced buttons into a single-entry
// valid/ready command slot for the burst sequencer, counting discarded events.
module fan_cmd_frontend
  import fan_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic [3:0]       btn_n,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd,
  output logic [7:0]       drop_count,
  output logic [3:0]       btn_state
);

  logic [3:0]       w_press;
  rx_decode_t       w_rx;
  logic             w_rx_hit;
  logic [2:0]       w_n_events;
  logic             w_win_valid;
  logic [CMD_W-1:0] w_win_code;
  logic             w_slot_free;
  logic             w_load;
  logic             w_drop;

  logic             r_valid;
  logic [CMD_W-1:0] r_cmd;
  logic [7:0]       r_drop_count;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_n  (btn_n[g]),
      .pressed(btn_state[g]),
      .press  (w_press[g])
    );
  end

  assign w_rx     = decode_rx(rx_data);
  assign w_rx_hit = rx_valid & w_rx.hit;

  always_comb begin
    w_n_events = {2'b00, w_rx_hit};
    for (int i = 0; i < 4; i++) begin
      w_n_events = w_n_events + {2'b00, w_press[i]};
    end
  end

  // UART beats buttons; descending scan so the lowest-index button is written last.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_code  = CMD_NONE;
    if (w_rx_hit) begin
      w_win_valid = 1'b1;
      w_win_code  = w_rx.code;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (w_press[i]) begin
          w_win_valid = 1'b1;
          w_win_code  = CMD_W'(i);
        end
      end
    end
  end

  assign w_slot_free = ~r_valid | cmd_ready;
  assign w_load      = w_win_valid & w_slot_free;
  assign w_drop      = (w_n_events > 3'd1) | (w_win_valid & ~w_slot_free);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_cmd        <= CMD_NONE;
      r_drop_count <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_cmd   <= w_win_code;
      end else if (r_valid && cmd_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign cmd_valid  = r_valid;
  assign cmd        = r_cmd;
  assign drop_count = r_drop_count;

endmodule
